// File: rtl/fp_subtractor_seq.sv
// Multi-cycle IEEE-754 single-precision subtractor (out = A - B), truncating,
// with a start/busy/done handshake and data-dependent iterative normalisation.
module fp_subtractor_seq #(
  parameter int EXP_W   = 8,
  parameter int MAN_W   = 23,
  parameter int MAX_NRM = 24
) (
  input  logic                 control,
  input  logic                 reset,
  input  logic                 start,
  input  logic [EXP_W+MAN_W:0] A,
  input  logic [EXP_W+MAN_W:0] B,
  output logic                 busy,
  output logic                 done,
  output logic [EXP_W+MAN_W:0] out,
  output logic                 exception
);

  localparam int DW        = EXP_W + MAN_W + 1;
  localparam int WW        = MAN_W + 4;  // hidden bit, fraction, guard, round, sticky
  localparam int CW        = $clog2(MAX_NRM + 1);
  localparam int ALIGN_MAX = MAN_W + 3;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_UNPACK = 3'd1;
  localparam logic [2:0] ST_ALIGN  = 3'd2;
  localparam logic [2:0] ST_SUB    = 3'd3;
  localparam logic [2:0] ST_NORM   = 3'd4;
  localparam logic [2:0] ST_PACK   = 3'd5;

  localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};
  localparam logic [DW-1:0]    QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  function automatic logic [DW-1:0] pack_word(input logic s, input logic [EXP_W-1:0] e,
                                              input logic [MAN_W-1:0] f);
    return {s, e, f};
  endfunction

  function automatic logic [DW-1:0] inf_word(input logic s);
    return {s, EXP_MAX, {MAN_W{1'b0}}};
  endfunction

  function automatic logic [DW-1:0] zero_word(input logic s);
    return {s, {(DW-1){1'b0}}};
  endfunction

  logic [2:0]       state_r, state_s;
  logic [DW-1:0]    a_r, a_s, b_r, b_s;
  logic             sign_big_r, sign_big_s, sign_sml_r, sign_sml_s;
  logic [EXP_W-1:0] exp_big_r, exp_big_s, exp_sml_r, exp_sml_s;
  logic [WW-1:0]    man_big_r, man_big_s, man_sml_r, man_sml_s;
  logic [WW-1:0]    sum_r, sum_s;
  logic [EXP_W-1:0] exp_r, exp_s;
  logic             sign_r, sign_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [DW-1:0]    out_r, out_s;
  logic             exc_r, exc_s, done_r, done_s, busy_r, busy_s;
  logic             fin_s, rexc_s;
  logic [DW-1:0]    res_s;

  logic [EXP_W-1:0] a_exp_s, b_exp_s;
  logic [MAN_W-1:0] a_frac_s, b_frac_s;
  logic             a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_zero_s, b_zero_s, b_neg_s;
  logic [EXP_W-1:0] diff_s;
  logic [WW-1:0]    sml_shift_s;
  logic             sml_lost_s;
  logic [WW:0]      sum_wide_s;
  logic [EXP_W:0]   exp_inc_s;
  logic [WW-1:0]    shl_s;
  logic [EXP_W-1:0] exp_dec_s;
  logic [CW-1:0]    cnt_inc_s;

  // Operand classification; exponent zero (denormal or zero) counts as zero
  assign a_exp_s  = a_r[DW-2:MAN_W];
  assign b_exp_s  = b_r[DW-2:MAN_W];
  assign a_frac_s = a_r[MAN_W-1:0];
  assign b_frac_s = b_r[MAN_W-1:0];
  assign a_nan_s  = (a_exp_s == EXP_MAX) && (a_frac_s != '0);
  assign b_nan_s  = (b_exp_s == EXP_MAX) && (b_frac_s != '0);
  assign a_inf_s  = (a_exp_s == EXP_MAX) && (a_frac_s == '0);
  assign b_inf_s  = (b_exp_s == EXP_MAX) && (b_frac_s == '0);
  assign a_zero_s = (a_exp_s == '0);
  assign b_zero_s = (b_exp_s == '0);
  assign b_neg_s  = ~b_r[DW-1];

  assign diff_s      = exp_big_r - exp_sml_r;
  assign sml_shift_s = man_sml_r >> diff_s;
  assign sml_lost_s  = |(man_sml_r & ~({WW{1'b1}} << diff_s));
  assign sum_wide_s  = (sign_big_r == sign_sml_r) ? ({1'b0, man_big_r} + {1'b0, man_sml_r})
                                                  : ({1'b0, man_big_r} - {1'b0, man_sml_r});
  assign exp_inc_s   = {1'b0, exp_big_r} + {{EXP_W{1'b0}}, 1'b1};
  assign shl_s       = sum_r << 1'b1;
  assign exp_dec_s   = exp_r - {{(EXP_W-1){1'b0}}, 1'b1};
  assign cnt_inc_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};

  // Next-state and datapath decisions; fin_s routes any finished result into PACK
  always_comb begin
    state_s    = state_r;
    a_s        = a_r;
    b_s        = b_r;
    sign_big_s = sign_big_r;
    sign_sml_s = sign_sml_r;
    exp_big_s  = exp_big_r;
    exp_sml_s  = exp_sml_r;
    man_big_s  = man_big_r;
    man_sml_s  = man_sml_r;
    sum_s      = sum_r;
    exp_s      = exp_r;
    sign_s     = sign_r;
    cnt_s      = cnt_r;
    out_s      = out_r;
    exc_s      = exc_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    fin_s      = 1'b0;
    rexc_s     = 1'b0;
    res_s      = '0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          a_s     = A;
          b_s     = B;
          busy_s  = 1'b1;
          state_s = ST_UNPACK;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_UNPACK: begin
        if (a_nan_s || b_nan_s) begin
          fin_s = 1'b1; res_s = QNAN; rexc_s = 1'b1;
        end else if (a_inf_s && b_inf_s) begin
          fin_s = 1'b1; rexc_s = 1'b1;
          res_s = (a_r[DW-1] == b_r[DW-1]) ? QNAN : a_r;
        end else if (a_inf_s) begin
          fin_s = 1'b1; res_s = a_r; rexc_s = 1'b1;
        end else if (b_inf_s) begin
          fin_s = 1'b1; res_s = {b_neg_s, b_r[DW-2:0]}; rexc_s = 1'b1;
        end else if (a_zero_s && b_zero_s) begin
          fin_s = 1'b1; res_s = zero_word(1'b0);
        end else if (a_zero_s) begin
          fin_s = 1'b1; res_s = {b_neg_s, b_r[DW-2:0]};
        end else if (b_zero_s) begin
          fin_s = 1'b1; res_s = a_r;
        end else if (b_r[DW-2:0] > a_r[DW-2:0]) begin
          sign_big_s = b_neg_s;   exp_big_s = b_exp_s; man_big_s = {1'b1, b_frac_s, 3'b000};
          sign_sml_s = a_r[DW-1]; exp_sml_s = a_exp_s; man_sml_s = {1'b1, a_frac_s, 3'b000};
          state_s    = ST_ALIGN;
        end else begin
          sign_big_s = a_r[DW-1]; exp_big_s = a_exp_s; man_big_s = {1'b1, a_frac_s, 3'b000};
          sign_sml_s = b_neg_s;   exp_sml_s = b_exp_s; man_sml_s = {1'b1, b_frac_s, 3'b000};
          state_s    = ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        if (diff_s > EXP_W'(ALIGN_MAX)) begin
          man_sml_s = '0;
        end else begin
          man_sml_s = sml_shift_s | {{(WW-1){1'b0}}, sml_lost_s};
        end
        state_s = ST_SUB;
      end
      ST_SUB: begin
        if (sum_wide_s == '0) begin
          fin_s = 1'b1; res_s = zero_word(1'b0);
        end else if (sum_wide_s[WW]) begin
          // Carry-out: the fraction sits one bit higher, exponent bumps by one
          fin_s = 1'b1;
          if (exp_inc_s >= {1'b0, EXP_MAX}) begin
            res_s = inf_word(sign_big_r); rexc_s = 1'b1;
          end else begin
            res_s = pack_word(sign_big_r, exp_inc_s[EXP_W-1:0], sum_wide_s[WW-1:4]);
          end
        end else if (sum_wide_s[WW-1]) begin
          fin_s = 1'b1;
          res_s = pack_word(sign_big_r, exp_big_r, sum_wide_s[WW-2:3]);
        end else begin
          sum_s   = sum_wide_s[WW-1:0];
          exp_s   = exp_big_r;
          sign_s  = sign_big_r;
          cnt_s   = '0;
          state_s = ST_NORM;
        end
      end
      ST_NORM: begin
        if (exp_dec_s == '0) begin
          fin_s = 1'b1; res_s = zero_word(sign_r);
        end else if (shl_s[WW-1]) begin
          fin_s = 1'b1; res_s = pack_word(sign_r, exp_dec_s, shl_s[WW-2:3]);
        end else if (cnt_inc_s == CW'(MAX_NRM)) begin
          fin_s = 1'b1; res_s = zero_word(sign_r);
        end else begin
          sum_s = shl_s;
          exp_s = exp_dec_s;
          cnt_s = cnt_inc_s;
        end
      end
      ST_PACK: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
    endcase
    // PACK is the done cycle: result registers load on the edge that enters it
    if (fin_s) begin
      state_s = ST_PACK;
      out_s   = res_s;
      exc_s   = rexc_s;
      done_s  = 1'b1;
      busy_s  = 1'b0;
    end else begin
      done_s  = 1'b0;
    end
  end

  // State and datapath registers, cleared by the asynchronous reset
  always_ff @(posedge control or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      a_r        <= '0;
      b_r        <= '0;
      sign_big_r <= 1'b0;
      sign_sml_r <= 1'b0;
      exp_big_r  <= '0;
      exp_sml_r  <= '0;
      man_big_r  <= '0;
      man_sml_r  <= '0;
      sum_r      <= '0;
      exp_r      <= '0;
      sign_r     <= 1'b0;
      cnt_r      <= '0;
      out_r      <= '0;
      exc_r      <= 1'b0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      a_r        <= a_s;
      b_r        <= b_s;
      sign_big_r <= sign_big_s;
      sign_sml_r <= sign_sml_s;
      exp_big_r  <= exp_big_s;
      exp_sml_r  <= exp_sml_s;
      man_big_r  <= man_big_s;
      man_sml_r  <= man_sml_s;
      sum_r      <= sum_s;
      exp_r      <= exp_s;
      sign_r     <= sign_s;
      cnt_r      <= cnt_s;
      out_r      <= out_s;
      exc_r      <= exc_s;
      done_r     <= done_s;
      busy_r     <= busy_s;
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign out       = out_r;
  assign exception = exc_r;

endmodule
